// File: rtl/scrambler_pkg.sv
// Shared constants for the 802.11 OFDM data scrambler: rate codes, LFSR taps, default seed.
// Combinational helpers only; no state, no flow control.
package scrambler_pkg;

  // RATE field codes R1..R4 as carried in tuser (ieee80211_defs)
  localparam logic [3:0] RATE_6M  = 4'b1011;
  localparam logic [3:0] RATE_9M  = 4'b1111;
  localparam logic [3:0] RATE_12M = 4'b1010;
  localparam logic [3:0] RATE_18M = 4'b1110;
  localparam logic [3:0] RATE_24M = 4'b1001;
  localparam logic [3:0] RATE_36M = 4'b1101;
  localparam logic [3:0] RATE_48M = 4'b1000;
  localparam logic [3:0] RATE_54M = 4'b1100;

  localparam int         SCRAMBLER_TAP_HI = 7;
  localparam int         SCRAMBLER_TAP_LO = 4;
  localparam logic [6:0] SCRAMBLER_DEFAULT_SEED = 7'h7F;

  typedef enum logic {
    ST_SIG  = 1'b0,
    ST_DATA = 1'b1
  } scr_state_e;

  // An all-zero state would lock the LFSR at zero.
  function automatic logic [6:0] seed_fix(input logic [6:0] s);
    return (s == 7'd0) ? SCRAMBLER_DEFAULT_SEED : s;
  endfunction

endpackage

// File: rtl/scrambler_lfsr_step.sv
// N-step unrolled x^7+x^4+1 scrambler; bit 0 is earliest in time.
// Purely combinational, zero latency, no flow control.
module scrambler_lfsr_step
  import scrambler_pkg::*;
#(
  parameter int N = 24
) (
  input  logic [6:0]   state_i,
  input  logic [N-1:0] data_i,
  output logic [N-1:0] scrambled_o,
  output logic [6:0]   next_state_o
);

  for (genvar i = 0; i < N; i++) begin : g_step
    logic [6:0] cur;
    logic [6:0] nxt;
    logic       b;

    if (i == 0) begin : g_first
      assign cur = state_i;
    end else begin : g_chain
      assign cur = g_step[i-1].nxt;
    end

    assign b              = cur[SCRAMBLER_TAP_HI-1] ^ cur[SCRAMBLER_TAP_LO-1];
    assign nxt            = {cur[5:0], b};
    assign scrambled_o[i] = data_i[i] ^ b;
  end

  assign next_state_o = g_step[N-1].nxt;

endmodule

// File: rtl/scrambler.sv
// 802.11 OFDM data scrambler: SIGNAL beat passed through at 6 Mb/s, data beats scrambled, tail bits zeroed.
// Latency 1 through a single output register; upstream stalls only while that register is held.
module scrambler
  import scrambler_pkg::*;
#(
  parameter int WIDTH     = 24,
  parameter bit SIGNAL_EN = 1'b1
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [6:0]       seed,
  input  logic [WIDTH-1:0] s_axis_tdata,
  input  logic [3:0]       s_axis_tuser,
  input  logic [WIDTH-1:0] s_axis_tzero,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tlast,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic [3:0]       m_axis_tuser,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast
);

  if (SIGNAL_EN && (WIDTH != 24)) begin : g_bad_width
    $error("scrambler: SIGNAL_EN requires WIDTH == 24");
  end

  localparam scr_state_e FRAME_START = SIGNAL_EN ? ST_SIG : ST_DATA;

  scr_state_e       state_q, state_d;
  logic [6:0]       lfsr_q, lfsr_d;
  logic             first_q, first_d;
  logic [WIDTH-1:0] tdata_q, tdata_d;
  logic [3:0]       tuser_q, tuser_d;
  logic             tlast_q, tlast_d;
  logic             tvalid_q, tvalid_d;

  logic             s_hs, m_hs;
  logic [6:0]       work_state;
  logic [6:0]       step_next;
  logic [WIDTH-1:0] step_scr;

  assign s_axis_tready = m_axis_tready | ~tvalid_q;
  assign s_hs          = s_axis_tvalid & s_axis_tready;
  assign m_hs          = tvalid_q & m_axis_tready;

  // The first data beat of a frame starts from the fresh seed, not the running LFSR.
  assign work_state = first_q ? seed_fix(seed) : lfsr_q;

  scrambler_lfsr_step #(.N(WIDTH)) u_step (
    .state_i      (work_state),
    .data_i       (s_axis_tdata),
    .scrambled_o  (step_scr),
    .next_state_o (step_next)
  );

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    first_d  = first_q;
    tdata_d  = tdata_q;
    tuser_d  = tuser_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q;
    if (s_hs) begin
      tvalid_d = 1'b1;
      tlast_d  = s_axis_tlast;
      if (state_q == ST_SIG) begin
        tdata_d = s_axis_tdata;
        tuser_d = RATE_6M;
        state_d = s_axis_tlast ? ST_SIG : ST_DATA;
        if (s_axis_tlast) first_d = 1'b1;
      end else begin
        tdata_d = step_scr & ~s_axis_tzero;
        tuser_d = s_axis_tuser;
        lfsr_d  = step_next;
        first_d = s_axis_tlast;
        state_d = s_axis_tlast ? FRAME_START : ST_DATA;
      end
    end else if (m_hs) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= FRAME_START;
      lfsr_q   <= SCRAMBLER_DEFAULT_SEED;
      first_q  <= 1'b1;
      tdata_q  <= '0;
      tuser_q  <= 4'd0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      first_q  <= first_d;
      tdata_q  <= tdata_d;
      tuser_q  <= tuser_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;

endmodule

// File: tb/tb_scrambler.sv
// Scoreboard bench for scrambler: SIGNAL_EN=1 instance checked beat-by-beat, SIGNAL_EN=0 instance checked directly.
module tb_scrambler;
  import scrambler_pkg::*;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;
  logic aresetn;

  logic [6:0]  seed;
  logic [23:0] s_tdata, s_tzero, m_tdata;
  logic [3:0]  s_tuser, m_tuser;
  logic        s_tvalid, s_tready, s_tlast, m_tvalid, m_tready, m_tlast;

  logic [6:0]  z_seed;
  logic [23:0] z_s_tdata, z_s_tzero, z_m_tdata;
  logic [3:0]  z_s_tuser, z_m_tuser;
  logic        z_s_tvalid, z_s_tready, z_s_tlast, z_m_tvalid, z_m_tready, z_m_tlast;

  scrambler #(.WIDTH(24), .SIGNAL_EN(1'b1)) u_dut (
    .aclk(aclk), .aresetn(aresetn), .seed(seed),
    .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser), .s_axis_tzero(s_tzero),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tuser(m_tuser), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast)
  );

  scrambler #(.WIDTH(24), .SIGNAL_EN(1'b0)) u_dut_nosig (
    .aclk(aclk), .aresetn(aresetn), .seed(z_seed),
    .s_axis_tdata(z_s_tdata), .s_axis_tuser(z_s_tuser), .s_axis_tzero(z_s_tzero),
    .s_axis_tvalid(z_s_tvalid), .s_axis_tready(z_s_tready), .s_axis_tlast(z_s_tlast),
    .m_axis_tdata(z_m_tdata), .m_axis_tuser(z_m_tuser), .m_axis_tvalid(z_m_tvalid),
    .m_axis_tready(z_m_tready), .m_axis_tlast(z_m_tlast)
  );

  typedef struct {
    logic [23:0] d;
    logic [3:0]  u;
    logic        l;
  } exp_t;

  exp_t        exp_q[$];
  logic [23:0] obs_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Reference model: bit-serial scrambler with frame tracking.
  bit         mdl_sig;
  bit         mdl_first;
  logic [6:0] mdl_lfsr;

  task automatic model_reset();
    mdl_sig   = 1'b1;
    mdl_first = 1'b1;
    mdl_lfsr  = 7'h7F;
  endtask

  task automatic model_accept(input logic [23:0] d, input logic [3:0] u, input logic [23:0] z,
                              input logic l, input logic [6:0] sd);
    exp_t       e;
    logic [6:0] st;
    logic       b;
    e.l = l;
    if (mdl_sig) begin
      e.d     = d;
      e.u     = RATE_6M;
      mdl_sig = l;
    end else begin
      st = mdl_first ? ((sd == 7'd0) ? 7'h7F : sd) : mdl_lfsr;
      for (int i = 0; i < 24; i++) begin
        b      = st[6] ^ st[3];
        e.d[i] = (d[i] ^ b) & ~z[i];
        st     = {st[5:0], b};
      end
      e.u       = u;
      mdl_lfsr  = st;
      mdl_first = l;
      mdl_sig   = l;
    end
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send(input logic [23:0] d, input logic [3:0] u, input logic [23:0] z,
                      input logic l, input logic [6:0] sd);
    logic rdy;
    bit   done;
    done     = 1'b0;
    s_tdata  = d;
    s_tuser  = u;
    s_tzero  = z;
    s_tlast  = l;
    seed     = sd;
    s_tvalid = 1'b1;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge aclk);
      rdy = s_tready;
      @(posedge aclk);
      #1;
      if (rdy) begin
        model_accept(d, u, z, l, sd);
        done = 1'b1;
      end
    end
    s_tvalid = 1'b0;
    if (!done) check("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(posedge aclk);
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Output monitor: pops the scoreboard on every output handshake and checks hold stability.
  exp_t        e_mon;
  logic        held_v = 1'b0;
  logic [23:0] held_d = '0;

  always @(negedge aclk) begin
    if (aresetn) begin
      if (held_v && m_tvalid) check("hold_stable", m_tdata, held_d);
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          e_mon = exp_q.pop_front();
          check("out_tdata", m_tdata, e_mon.d);
          check("out_tuser", m_tuser, e_mon.u);
          check("out_tlast", m_tlast, e_mon.l);
          obs_q.push_back(m_tdata);
        end
      end
      held_v = m_tvalid && !m_tready;
      held_d = m_tdata;
    end else begin
      held_v = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int          base;
    logic [23:0] beat2;

    aresetn  = 1'b0;
    seed     = 7'h7F;
    s_tdata  = '0; s_tuser = 4'd0; s_tzero = '0; s_tlast = 1'b0; s_tvalid = 1'b0;
    m_tready = 1'b1;
    z_seed   = 7'h7F;
    z_s_tdata = '0; z_s_tuser = RATE_24M; z_s_tzero = '0; z_s_tlast = 1'b1; z_s_tvalid = 1'b0;
    z_m_tready = 1'b1;
    model_reset();

    repeat (3) @(posedge aclk);
    #1;
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_tuser", m_tuser, 0);
    check("rst_tlast", m_tlast, 0);
    check("rst_nosig_tvalid", z_m_tvalid, 0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // SIGNAL_EN=0: one-beat frames, seed 7F then seed 0 (must reload 7F each frame)
    z_s_tvalid = 1'b1;
    @(posedge aclk);
    #1;
    z_s_tvalid = 1'b0;
    check("nosig_tvalid", z_m_tvalid, 1);
    check("nosig_tdata", z_m_tdata, 24'h934F70);
    check("nosig_tlast", z_m_tlast, 1);
    check("nosig_tuser", z_m_tuser, RATE_24M);
    z_seed     = 7'h00;
    z_s_tvalid = 1'b1;
    @(posedge aclk);
    #1;
    z_s_tvalid = 1'b0;
    check("nosig_seed0_tdata", z_m_tdata, 24'h934F70);

    // SIGNAL pass-through and first data beats
    base = obs_q.size();
    send(24'h00A5B1, RATE_54M, 24'h0, 1'b0, 7'h7F);
    send(24'h0,      RATE_54M, 24'h0, 1'b0, 7'h7F);
    send(24'h0,      RATE_54M, 24'h0, 1'b1, 7'h7F);
    drain();
    check("sig_passthru", obs_q[base], 24'h00A5B1);
    check("first_data", obs_q[base+1], 24'h934F70);
    beat2 = obs_q[base+2];

    // Tail mask: output masked, LFSR still advances
    base = obs_q.size();
    send(24'h123456, RATE_36M, 24'h0,      1'b0, 7'h7F);
    send(24'h0,      RATE_36M, 24'hFC0000, 1'b0, 7'h7F);
    send(24'h0,      RATE_36M, 24'h0,      1'b1, 7'h7F);
    drain();
    check("tail_mask", obs_q[base+1], 24'h034F70);
    check("tail_lfsr_adv", obs_q[base+2], beat2);

    // 127-beat period; seed changed after the first data beat must be ignored
    base = obs_q.size();
    send(24'hFFFFFF, RATE_12M, 24'h0, 1'b0, 7'h5D);
    for (int k = 0; k < 128; k++)
      send(24'h0, RATE_12M, 24'h0, (k == 127), (k == 0) ? 7'h5D : 7'h11);
    drain();
    check("period_127", obs_q[base+128], obs_q[base+1]);

    // Backpressure: 5 cycles of m_tready=0 while beats are offered
    base = obs_q.size();
    fork
      begin
        send(24'h0ABCDE, RATE_18M, 24'h0, 1'b0, 7'h7F);
        send(24'h0, RATE_18M, 24'h0, 1'b0, 7'h7F);
        send(24'h0, RATE_18M, 24'h0, 1'b0, 7'h7F);
        send(24'h0, RATE_18M, 24'h0, 1'b1, 7'h7F);
      end
      begin
        @(posedge aclk);
        #1;
        m_tready = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        check("bp_s_tready_low", s_tready, 0);
        check("bp_m_tvalid_held", m_tvalid, 1);
        repeat (3) @(posedge aclk);
        #1;
        m_tready = 1'b1;
      end
    join
    drain();
    check("bp_count", obs_q.size() - base, 4);
    check("bp_seq1", obs_q[base+1], 24'h934F70);
    check("bp_seq2", obs_q[base+2], beat2);

    // Reset mid-frame: pending beat discarded, next frame starts in SIG with seed reload
    send(24'h000111, RATE_9M, 24'h0, 1'b0, 7'h33);
    send(24'h0,      RATE_9M, 24'h0, 1'b0, 7'h33);
    m_tready = 1'b0;
    aresetn  = 1'b0;
    @(posedge aclk);
    #1;
    check("rst_mid_tvalid", m_tvalid, 0);
    aresetn  = 1'b1;
    m_tready = 1'b1;
    exp_q.delete();
    model_reset();
    base = obs_q.size();
    send(24'h00BEEF, RATE_48M, 24'h0, 1'b0, 7'h00);
    send(24'h0,      RATE_48M, 24'h0, 1'b1, 7'h00);
    drain();
    check("rst_sig_first", obs_q[base], 24'h00BEEF);
    check("rst_seed0_reload", obs_q[base+1], 24'h934F70);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/scrambler.md
Name: scrambler

Overview:
- IEEE 802.11 OFDM PHY data scrambler, x^7 + x^4 + 1.
- Sits directly upstream of the convolutional encoder and feeds it WIDTH-bit AXI-Stream beats carrying the rate in tuser.
- Passes the SIGNAL field through unscrambled and forces it to the 6 Mb/s rate code.
- Scrambles SERVICE/PSDU/pad bits with a per-frame seed.
- Zeroes the 6 tail bits after scrambling, at positions given by a per-beat mask.

Parameters:
- WIDTH, 24: bits per beat. Bit 0 is the earliest bit in time, matching encoder bit order.
- SIGNAL_EN, 1: first beat of every frame is the SIGNAL field. Requires WIDTH == 24; elaboration error otherwise.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset
- seed  in  7  scrambler seed, sampled on the first DATA beat of each frame; 0 is illegal and replaced by 7'h7F
- s_axis_tdata  in  WIDTH  unscrambled bits
- s_axis_tuser  in  4  rate code (ieee80211_defs RATE_*)
- s_axis_tzero  in  WIDTH  per-bit mask; 1 forces the output bit to 0 (tail bits)
- s_axis_tvalid  in  1  upstream valid
- s_axis_tready  out  1  ready to upstream
- s_axis_tlast  in  1  last beat of frame
- m_axis_tdata  out  WIDTH  scrambled bits
- m_axis_tuser  out  4  rate code to the encoder
- m_axis_tvalid  out  1  valid to the encoder
- m_axis_tready  in  1  encoder ready
- m_axis_tlast  out  1  last beat of frame

Behaviour:
- Reset (aresetn): synchronous, active-low; clock aclk.
  - Reset values: m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0, m_axis_tvalid=0.
  - Internal state: state=SIG (DATA if SIGNAL_EN=0), lfsr=7'h7F.
- Handshakes:
  - s_axis_tready = m_axis_tready | ~m_axis_tvalid.
  - s_hs = s_axis_tvalid & s_axis_tready.
  - m_hs = m_axis_tvalid & m_axis_tready.
- Output register, single stage, latency 1:
  - On s_hs: load tdata/tuser/tlast and set tvalid=1.
  - Else on m_hs: tvalid=0.
  - Output holds stable while tvalid=1 and tready=0.
  - No bubble in throughput at full rate.
- States (update on s_hs only):
  - SIG: out tdata = in tdata (unscrambled, tzero not applied); out tuser = `RATE_6M; lfsr unchanged. Next state DATA, or SIG if tlast (degenerate one-beat frame).
  - DATA: scramble as below; out tuser = in tuser. Next state SIG (or DATA if SIGNAL_EN=0) on tlast, else DATA.
- Seed load: on the first DATA beat of a frame, the working state is seed (7'h7F if seed==0), not lfsr. Tracked by a first_data flag, set on reset and on tlast, cleared on the first DATA s_hs.
- Scrambler math, per bit i = 0..WIDTH-1 in order:
  - Starting state s = lfsr, with s[6] = x7 and s[3] = x4.
  - b_i = s[6] ^ s[3]; s <= {s[5:0], b_i}.
  - out[i] = (in[i] ^ b_i) & ~tzero[i].
  - New lfsr = s after WIDTH steps.
  - Implemented as a combinational unrolled WIDTH-step function (generate loop); no multicycle.
- Boundary conditions:
  - tzero affects output only; the LFSR always advances WIDTH steps per DATA beat.
  - The sequence period is 127 bits; the state after 127 DATA beats equals the seed.
  - tlast on a DATA beat with simultaneous m_hs of the previous beat: both complete in the same cycle; the next beat is SIG.
  - Reset mid-frame: frame is discarded. Output tvalid drops the next cycle, and the next accepted beat is treated as SIG.
  - s_axis_tvalid low: no state change.
  - seed changes mid-frame: ignored until the next frame's first DATA beat.

Decomposition:
- Package/defines: RATE_* codes (existing ieee80211_defs), SCRAMBLER_POLY taps (7,4), default seed 7'h7F, state encodings SIG/DATA.
- Sub-module: scrambler_lfsr_step. Purely combinational, parameter N; inputs state[6:0] and data[N-1:0]; outputs scrambled[N-1:0] and next_state[6:0]. Reusable by the receive-side descrambler.

Test Plan:
- SIGNAL_EN=0, seed=7'h7F, one all-zero beat with tzero=0 -> m_axis_tdata=24'h934F70 (sequence 00001110 11110010 11001001, LSB first), tlast propagated.
- SIGNAL_EN=1, beat0 tdata=24'h00A5B1 with tuser=`RATE_54M, then beat1 zeros with seed=7'h7F -> out0 = 24'h00A5B1 with tuser=`RATE_6M; out1 = 24'h934F70 with tuser=`RATE_54M.
- 128 all-zero DATA beats, seed=7'h5D -> beat 127 output equals beat 0 output (127-beat period).
- Tail mask: zero data, seed 7'h7F, tzero=24'hFC0000 -> out=24'h034F70. Next beat equals unmasked beat 2 of the sequence (LFSR still advanced).
- Backpressure: hold m_axis_tready=0 for 5 cycles with 3 beats offered -> s_axis_tready=0 after the first accept, output stable, no beat lost or duplicated; the sequence matches the no-backpressure run.
- seed=0 -> behaves as 7'h7F. Assert aresetn low mid-frame -> tvalid=0 next cycle; the next frame starts in SIG and reloads seed.
